seq_detector_param: RTL
=======================

# seq_detector_param

Parametrised serial sequence detector, the next generation of the fixed-pattern detector. It accepts a valid-qualified serial bit stream and matches it against a runtime-loadable pattern of programmable length, up to `MAX_LEN` bits. Overlapping or non-overlapping detection is selectable per cycle. A saturating match counter is included. It sits between a serial deserialiser front end and the control logic that consumes match events.

## Interface
- `MAX_LEN`, 8: maximum pattern length in bits (≥2).
- `CNT_WIDTH`, 8: width of the match counter.
- `DEFAULT_PATTERN`, `MAX_LEN'b1011`: pattern loaded at reset.
- `DEFAULT_LEN`, 4: pattern length loaded at reset.
- `LW`: local, `$clog2(MAX_LEN+1)`.

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-low; `reset==0` at a rising edge resets.
- `data_valid` in 1: `data_in` is accepted on this cycle.
- `data_in` in 1: serial data bit.
- `cfg_load` in 1: latch `cfg_pattern` and `cfg_len` at this edge.
- `cfg_pattern` in `MAX_LEN`: new pattern; bit `[len-1]` is the first bit received, bit `[0]` the last.
- `cfg_len` in `LW`: new length. 0 disables detection; values above `MAX_LEN` clamp to `MAX_LEN`.
- `overlap_en` in 1: 1 = overlapping, 0 = non-overlapping. Sampled live each cycle.
- `cnt_clear` in 1: clears the match counter.
- `detected` out 1: registered one-cycle pulse per match.
- `match_count` out `CNT_WIDTH`: number of matches, saturating.
- `count_sat` out 1: high while `match_count` is all-ones.

## Operation
- State:
  - history shift register `hist[MAX_LEN-1:0]`;
  - fill counter `fill` (0..`MAX_LEN`, saturating), counting bits accepted since the last clear;
  - pattern register `pat` and length register `len`.
- Accept (`data_valid=1`, `cfg_load=0`):
  - `hist <= {hist[MAX_LEN-2:0], data_in}`;
  - `fill <= min(fill+1, MAX_LEN)`.
- Match condition, evaluated combinationally in the accepting cycle: `len != 0`, and `fill+1 >= len`, and the low `len` bits of `{hist[MAX_LEN-2:0], data_in}` equal `pat[len-1:0]`.
- On a match:
  - `detected` is 1 on the next cycle.
  - If `overlap_en=0`, `fill` is cleared to 0 (instead of incrementing), so no bit of the matched sequence can be reused.
  - If `overlap_en=1`, `fill` behaves normally.
- `data_valid=0`: `hist`, `fill` and `detected` hold state, except that `detected` returns to 0. `data_in` is ignored.
- `cfg_load=1`:
  - `pat <= cfg_pattern`;
  - `len <= clamp(cfg_len)`;
  - `hist` and `fill` are cleared.
  - Any `data_valid`/`data_in` in the same cycle is discarded.
  - No match is evaluated in that cycle.
- Counter:
  - On a match, `match_count` increments on the same edge that raises `detected`.
  - It holds at `2^CNT_WIDTH-1` once saturated.
  - `count_sat` is the registered equality with all-ones.
  - `cnt_clear` zeroes the counter and `count_sat`; it has priority over a simultaneous match. `detected` still pulses.
- Reset values:
  - `hist=0`, `fill=0`, `pat=DEFAULT_PATTERN`, `len=DEFAULT_LEN`;
  - `detected=0`, `match_count=0`, `count_sat=0`.
- Reset has priority over `cfg_load`, `cnt_clear` and data.

## Timing
- Latency: `detected` rises exactly 1 cycle after the edge that accepts the final pattern bit. It is high for exactly 1 cycle per match.
- In overlap mode, back-to-back matches give consecutive-cycle pulses. Example: pattern `111`, `len=3`, continuous 1s.
- A reset mid-sequence discards partial history. A full `len` bits must be accepted after reset before any match.
- `cfg_load` mid-sequence behaves the same way: earliest match is `len` accepted bits after the load edge.
- `len=1`: every accepted bit equal to `pat[0]` matches; `fill` gating is trivially met.
- `len=MAX_LEN`: the entire `hist` is compared. `fill` saturation must not wrap.

## Test plan
- Defaults (`1011`, `len=4`), `overlap_en=1`, stream 1,0,1,1,0,1,1 with continuous valid → `detected` pulses 1 cycle after bits 4 and 7; `match_count=2`.
- Same stream with `overlap_en=0` → single pulse after bit 4; `match_count=1`.
- Same stream as the first scenario with `data_valid=0` gaps of 1–3 cycles carrying random `data_in` → pulses after bits 4 and 7 (accepted-bit count), 1 cycle after each accepting edge; `match_count=2`.
- `cfg_load` with `cfg_pattern=111`, `cfg_len=3` after two accepted 1s, then five 1s, overlap on → pulses after the 3rd, 4th and 5th post-load bits; `match_count=3`.
- `CNT_WIDTH=4`, pattern `1`, `len=1`, 17 accepted 1s → `match_count=15`, `count_sat=1`, `detected` still pulses.
  - `cnt_clear` asserted together with an 18th match → count 0, `count_sat=0`, `detected=1`.
- `reset=0` for one cycle after 1,0,1, then 1 → no pulse.
  - Then 1,0,1,1 → pulse.
  - Then load `cfg_len=0` and stream 1,0,1,1 → no pulse.
  - Then load `cfg_len=15` → effective `len=8`.

Source files
------------

// File: rtl/seq_detector_param.sv
// ============================================================================
// Module      : seq_detector_param
// Description : Serial bit-stream detector matching a runtime-loadable pattern
//               of programmable length, with saturating match counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_detector_param #(
    parameter int                 MAX_LEN         = 8,
    parameter int                 CNT_WIDTH       = 8,
    parameter logic [MAX_LEN-1:0] DEFAULT_PATTERN = MAX_LEN'(4'b1011),
    parameter int                 DEFAULT_LEN     = 4,
    localparam int                LW              = $clog2(MAX_LEN + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 data_valid,
    input  logic                 data_in,
    input  logic                 cfg_load,
    input  logic [MAX_LEN-1:0]   cfg_pattern,
    input  logic [LW-1:0]        cfg_len,
    input  logic                 overlap_en,
    input  logic                 cnt_clear,
    output logic                 detected,
    output logic [CNT_WIDTH-1:0] match_count,
    output logic                 count_sat
);

    localparam logic [LW-1:0]        c_max_len = LW'(MAX_LEN);
    localparam logic [LW:0]          c_one_w   = (LW+1)'(1);
    localparam logic [LW-1:0]        c_one_f   = LW'(1);
    localparam logic [CNT_WIDTH-1:0] c_one_c   = CNT_WIDTH'(1);

    logic [MAX_LEN-1:0]   r_hist;
    logic [LW-1:0]        r_fill;
    logic [MAX_LEN-1:0]   r_pat;
    logic [LW-1:0]        r_len;
    logic                 r_detected;
    logic [CNT_WIDTH-1:0] r_count;
    logic                 r_count_sat;

    logic [MAX_LEN-1:0]   w_shifted;
    logic [MAX_LEN-1:0]   w_mask;
    logic                 w_fill_ok;
    logic                 w_match;
    logic [LW-1:0]        w_fill_next;
    logic [LW-1:0]        w_len_clamped;
    logic [CNT_WIDTH-1:0] w_cnt_next;

    always_comb begin
        w_shifted = {r_hist[MAX_LEN-2:0], data_in};
        w_mask    = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            w_mask[i] = (i < int'(r_len));
        end
        // The bit being accepted counts toward the fill requirement.
        w_fill_ok = (({1'b0, r_fill} + c_one_w) >= {1'b0, r_len});
        w_match   = data_valid && !cfg_load && (r_len != '0) && w_fill_ok &&
                    ((w_shifted & w_mask) == (r_pat & w_mask));

        if (w_match && !overlap_en) begin
            w_fill_next = '0;
        end else if (r_fill == c_max_len) begin
            w_fill_next = r_fill;
        end else begin
            w_fill_next = r_fill + c_one_f;
        end

        w_len_clamped = (cfg_len > c_max_len) ? c_max_len : cfg_len;

        if (cnt_clear) begin
            w_cnt_next = '0;
        end else if (w_match && !(&r_count)) begin
            w_cnt_next = r_count + c_one_c;
        end else begin
            w_cnt_next = r_count;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_hist      <= '0;
            r_fill      <= '0;
            r_pat       <= DEFAULT_PATTERN;
            r_len       <= LW'(DEFAULT_LEN);
            r_detected  <= 1'b0;
            r_count     <= '0;
            r_count_sat <= 1'b0;
        end else begin
            r_detected  <= w_match;
            r_count     <= w_cnt_next;
            r_count_sat <= &w_cnt_next;
            if (cfg_load) begin
                r_pat  <= cfg_pattern;
                r_len  <= w_len_clamped;
                r_hist <= '0;
                r_fill <= '0;
            end else if (data_valid) begin
                r_hist <= w_shifted;
                r_fill <= w_fill_next;
            end
        end
    end

    assign detected    = r_detected;
    assign match_count = r_count;
    assign count_sat   = r_count_sat;

endmodule

`default_nettype wire
